// File: rtl/xor_nn_backprop.sv
// Backward-pass engine for the 2-3-1 XOR network: deltas plus one SGD step on the weights it owns.
// Latency: done pulses in the 12th cycle after the accepting edge; next accept is possible once back in IDLE.
// Backpressure: start is sampled only in IDLE; start while busy is dropped, not queued.
//
// Ports: clock/reset_n (async, active-low); start, x, target, a2_flat, a3 are the sample and
// its forward activations, all latched on acceptance. busy/done report progress. w1_flat,
// w2_flat, b1_flat and b2 drive the current weights to the forward block. update_count
// counts committed updates and wraps.
// Build option: define XNN_SAT_EN to clamp every weight/bias write; otherwise writes wrap.
module xor_nn_backprop #(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int LR_SHIFT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            x,
  input  logic                  target,
  input  logic [3*DATA_W-1:0]   a2_flat,
  input  logic [DATA_W-1:0]     a3,
  output logic                  busy,
  output logic                  done,
  output logic [6*DATA_W-1:0]   w1_flat,
  output logic [3*DATA_W-1:0]   w2_flat,
  output logic [3*DATA_W-1:0]   b1_flat,
  output logic [DATA_W-1:0]     b2,
  output logic [CNT_W-1:0]      update_count
);

  // Intermediate width: roomy enough for any product of two DATA_W codes
  // (including the DATA_W+1 bit differences One-a and a3-tgt).
  localparam int PW = 2*DATA_W + 2;
  // Weight subtractions run in DATA_W+2 bits before narrowing.
  localparam int NW = DATA_W + 2;

  typedef logic signed [DATA_W-1:0] dat_t;
  typedef logic signed [PW-1:0]     wide_t;
  typedef logic signed [NW-1:0]     nar_t;

  localparam wide_t MAX_P = PW'(2**(DATA_W-1) - 1);
  localparam wide_t MIN_P = PW'(-(2**(DATA_W-1)));
  localparam nar_t  MAX_N = NW'(2**(DATA_W-1) - 1);
  localparam nar_t  MIN_N = NW'(-(2**(DATA_W-1)));
  localparam wide_t ONE_P = PW'(2**FRAC_W);
  localparam dat_t  ONE_D = DATA_W'(2**FRAC_W);

  typedef enum logic [2:0] {
    IDLE, DELTA_OUT, DELTA_HID, UPD_W2, UPD_W1, DONE_S
  } state_t;

  state_t     state;
  logic [1:0] idx;
  dat_t       w1 [6];
  dat_t       w2 [3];
  dat_t       b1 [3];
  dat_t       b2_r;
  dat_t       d3;
  dat_t       d2 [3];
  dat_t       a2_l [3];
  dat_t       a3_l;
  logic [1:0] x_l;
  logic       tgt_l;

  function automatic wide_t ext(input dat_t a);
    return PW'(a);
  endfunction

  function automatic dat_t sat_p(input wide_t v);
    if (v > MAX_P)      return dat_t'(MAX_P);
    else if (v < MIN_P) return dat_t'(MIN_P);
    else                return dat_t'(v);
  endfunction

  // Weight write narrowing: clamp or two's-complement wrap.
  function automatic dat_t narrow(input nar_t r);
`ifdef XNN_SAT_EN
    if (r > MAX_N)      return dat_t'(MAX_N);
    else if (r < MIN_N) return dat_t'(MIN_N);
    else                return dat_t'(r);
`else
    return dat_t'(r);
`endif
  endfunction

  // Fixed-point product, floor-rounded by the arithmetic shift.
  function automatic wide_t mul_sh(input dat_t a, input dat_t b);
    return (ext(a) * ext(b)) >>> FRAC_W;
  endfunction

  // Sigmoid derivative a*(1-a), saturated to the data range.
  function automatic dat_t sig_d(input dat_t a);
    return sat_p((ext(a) * (ONE_P - ext(a))) >>> FRAC_W);
  endfunction

  function automatic dat_t calc_d3(input dat_t a, input logic t);
    dat_t tg;
    tg = t ? ONE_D : '0;
    return sat_p(((ext(a) - ext(tg)) * ext(sig_d(a))) >>> FRAC_W);
  endfunction

  function automatic dat_t calc_d2(input dat_t w, input dat_t d, input dat_t a);
    return sat_p(mul_sh(sat_p(mul_sh(w, d)), sig_d(a)));
  endfunction

  function automatic dat_t upd(input dat_t w, input wide_t term);
    nar_t r;
    r = NW'(ext(w)) - NW'(term);
    return narrow(r);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      update_count <= '0;
      w1[0] <= dat_t'(47); w1[1] <= dat_t'(61);
      w1[2] <= dat_t'(35); w1[3] <= dat_t'(46);
      w1[4] <= dat_t'(55); w1[5] <= dat_t'(37);
      w2[0] <= dat_t'(75); w2[1] <= dat_t'(44); w2[2] <= dat_t'(66);
      b1[0] <= dat_t'(23); b1[1] <= dat_t'(7);  b1[2] <= dat_t'(13);
      b2_r  <= dat_t'(33);
      d3    <= '0;
      a3_l  <= '0;
      x_l   <= '0;
      tgt_l <= 1'b0;
      for (int j = 0; j < 3; j++) begin
        d2[j]   <= '0;
        a2_l[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < 3; j++) a2_l[j] <= dat_t'(a2_flat[j*DATA_W +: DATA_W]);
            a3_l  <= dat_t'(a3);
            x_l   <= x;
            tgt_l <= target;
            busy  <= 1'b1;
            state <= DELTA_OUT;
          end
        end
        DELTA_OUT: begin
          d3    <= calc_d3(a3_l, tgt_l);
          idx   <= '0;
          state <= DELTA_HID;
        end
        DELTA_HID: begin
          // W2 is still the pre-update value here since UPD_W2 comes later.
          d2[idx] <= calc_d2(w2[idx], d3, a2_l[idx]);
          if (idx == 2'd2) begin
            idx   <= '0;
            state <= UPD_W2;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        UPD_W2: begin
          if (idx == 2'd3) begin
            b2_r  <= upd(b2_r, ext(d3) >>> LR_SHIFT);
            idx   <= '0;
            state <= UPD_W1;
          end else begin
            w2[idx] <= upd(w2[idx], mul_sh(d3, a2_l[idx]) >>> LR_SHIFT);
            idx     <= idx + 2'd1;
          end
        end
        UPD_W1: begin
          w1[{idx, 1'b0}] <= upd(w1[{idx, 1'b0}], x_l[0] ? (ext(d2[idx]) >>> LR_SHIFT) : '0);
          w1[{idx, 1'b1}] <= upd(w1[{idx, 1'b1}], x_l[1] ? (ext(d2[idx]) >>> LR_SHIFT) : '0);
          b1[idx]         <= upd(b1[idx], ext(d2[idx]) >>> LR_SHIFT);
          if (idx == 2'd2) begin
            idx          <= '0;
            done         <= 1'b1;
            update_count <= update_count + 1'b1;
            state        <= DONE_S;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE_S: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  genvar g;
  for (g = 0; g < 6; g++) begin : g_w1
    assign w1_flat[g*DATA_W +: DATA_W] = w1[g];
  end
  for (g = 0; g < 3; g++) begin : g_w2b1
    assign w2_flat[g*DATA_W +: DATA_W] = w2[g];
    assign b1_flat[g*DATA_W +: DATA_W] = b1[g];
  end
  assign b2 = b2_r;

endmodule
